// File: rtl/banco_registradores_sb_if.sv
// Bus between the issue stage (master) and the register file with scoreboard (slave).
// Carries read ports, the write port, the reserve port and the hazard/status outputs.
interface banco_registradores_sb_if #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 5
);
    logic [AW-1:0] rd_addr_a;
    logic [W-1:0]  rd_data_a;
    logic [AW-1:0] rd_addr_b;
    logic [W-1:0]  rd_data_b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr;
    logic          busy_a;
    logic          busy_b;
    logic          hazard;
    logic [AW:0]   pend_count;
    logic          ready;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data_a, rd_data_b, busy_a, busy_b, hazard, pend_count, ready
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data_a, rd_data_b, busy_a, busy_b, hazard, pend_count, ready
    );
endinterface

// File: rtl/banco_registradores_sb.sv
// 2-read/1-write register file with per-register pending-write scoreboard and zeroing init.
// Optional same-cycle write-to-read forwarding when RF_BYPASS_EN is defined.
module banco_registradores_sb #(
    parameter int unsigned W        = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    banco_registradores_sb_if.slave bus
);
    localparam int unsigned N = 2 ** AW;
    localparam logic [AW-1:0] IdxLast = {AW{1'b1}};

    typedef enum logic {StInit, StRun} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [N-1:0]  busy_q, busy_d;
    logic [AW:0]   pend_q, pend_d;
    logic          ready_q;
    logic [W-1:0]  mem [N];

    logic          run, wr_eff, rsv_eff, pend_set, pend_clr;
    logic          zero_a, zero_b, bsy_a, bsy_b;
    logic [W-1:0]  rd_a, rd_b;

    assign run     = (state_q == StRun);
    assign wr_eff  = run && bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
    assign rsv_eff = run && bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));
    assign zero_a  = (ZERO_REG != 0) && (bus.rd_addr_a == '0);
    assign zero_b  = (ZERO_REG != 0) && (bus.rd_addr_b == '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StInit: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == IdxLast) state_d = StRun;
            end
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    // Reservation is applied after the release so a same-address pair leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (wr_eff)  busy_d[bus.wr_addr]  = 1'b0;
        if (rsv_eff) busy_d[bus.rsv_addr] = 1'b1;
        pend_set = rsv_eff && !busy_q[bus.rsv_addr];
        pend_clr = wr_eff && busy_q[bus.wr_addr]
                   && !(rsv_eff && (bus.rsv_addr == bus.wr_addr));
        pend_d   = pend_q + {{AW{1'b0}}, pend_set} - {{AW{1'b0}}, pend_clr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            idx_q   <= '0;
            busy_q  <= '0;
            pend_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            ready_q <= (state_d == StRun);
        end
    end

    // Array is not reset; INIT walks it to zero instead.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[idx_q] <= '0;
        end else if (wr_eff) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        rd_a  = mem[bus.rd_addr_a];
        rd_b  = mem[bus.rd_addr_b];
        bsy_a = busy_q[bus.rd_addr_a];
        bsy_b = busy_q[bus.rd_addr_b];
`ifdef RF_BYPASS_EN
        if (wr_eff && (bus.wr_addr == bus.rd_addr_a)) begin
            rd_a = bus.wr_data;
            if (!(rsv_eff && (bus.rsv_addr == bus.rd_addr_a))) bsy_a = 1'b0;
        end
        if (wr_eff && (bus.wr_addr == bus.rd_addr_b)) begin
            rd_b = bus.wr_data;
            if (!(rsv_eff && (bus.rsv_addr == bus.rd_addr_b))) bsy_b = 1'b0;
        end
`endif
        if (!run || zero_a) begin
            rd_a  = '0;
            bsy_a = 1'b0;
        end
        if (!run || zero_b) begin
            rd_b  = '0;
            bsy_b = 1'b0;
        end
    end

    assign bus.rd_data_a  = rd_a;
    assign bus.rd_data_b  = rd_b;
    assign bus.busy_a     = bsy_a;
    assign bus.busy_b     = bsy_b;
    assign bus.hazard     = bsy_a | bsy_b;
    assign bus.pend_count = pend_q;
    assign bus.ready      = ready_q;
endmodule
